// File: rtl/tft_power_sequencer.sv
// TFT panel power sequencer: brings up supply, video timing and backlight in order,
// and tears them down in reverse order, with minimum off-time before a restart.
module tft_power_sequencer #(
   parameter int unsigned T_PWR_UP_CYCLES   = 2000000,
   parameter int unsigned SYNC_FRAMES       = 4,
   parameter int unsigned T_BL_OFF_CYCLES   = 1000000,
   parameter int unsigned STOP_FRAMES       = 2,
   parameter int unsigned T_PWR_DOWN_CYCLES = 1000000,
   parameter int unsigned T_OFF_MIN_CYCLES  = 5000000
) (
   input  logic       i_master_clk,
   input  logic       i_reset_n,
   input  logic       i_power_request,
   input  logic       i_frame_tick,
   output logic       o_panel_power_en,
   output logic       o_timing_enabled,
   output logic       o_timing_reset_request,
   output logic       o_backlight_en,
   output logic       o_ready,
   output logic [2:0] o_state
);

   localparam logic [2:0] S_OFF       = 3'd0;
   localparam logic [2:0] S_PWR_UP    = 3'd1;
   localparam logic [2:0] S_SYNC_WAIT = 3'd2;
   localparam logic [2:0] S_ON        = 3'd3;
   localparam logic [2:0] S_BL_OFF    = 3'd4;
   localparam logic [2:0] S_STOP_WAIT = 3'd5;
   localparam logic [2:0] S_PWR_DOWN  = 3'd6;

   localparam int unsigned MAX_1   = (T_PWR_UP_CYCLES > T_BL_OFF_CYCLES) ? T_PWR_UP_CYCLES : T_BL_OFF_CYCLES;
   localparam int unsigned MAX_2   = (MAX_1 > T_PWR_DOWN_CYCLES) ? MAX_1 : T_PWR_DOWN_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_2 > T_OFF_MIN_CYCLES) ? MAX_2 : T_OFF_MIN_CYCLES;
   localparam int          DW      = $clog2(MAX_CYC) + 1;

   localparam int unsigned SYNC_EFF = (SYNC_FRAMES < 1) ? 1 : SYNC_FRAMES;
   localparam int unsigned STOP_EFF = (STOP_FRAMES < 1) ? 1 : STOP_FRAMES;
   localparam int unsigned FMAX     = (SYNC_EFF > STOP_EFF) ? SYNC_EFF : STOP_EFF;
   localparam int          FW       = $clog2(FMAX + 1);

   // Delay states load N-1 on entry and exit when the counter reads 0, so they last N cycles.
   localparam logic [DW-1:0] LD_PWR_UP   = (T_PWR_UP_CYCLES   > 1) ? DW'(T_PWR_UP_CYCLES   - 1) : '0;
   localparam logic [DW-1:0] LD_BL_OFF   = (T_BL_OFF_CYCLES   > 1) ? DW'(T_BL_OFF_CYCLES   - 1) : '0;
   localparam logic [DW-1:0] LD_PWR_DOWN = (T_PWR_DOWN_CYCLES > 1) ? DW'(T_PWR_DOWN_CYCLES - 1) : '0;
   localparam logic [DW-1:0] LD_OFF_MIN  = (T_OFF_MIN_CYCLES  > 1) ? DW'(T_OFF_MIN_CYCLES  - 1) : '0;
   localparam logic [FW:0]   SYNC_N      = (FW + 1)'(SYNC_EFF);
   localparam logic [FW:0]   STOP_N      = (FW + 1)'(STOP_EFF);

   logic [2:0]    r_state;
   logic [DW-1:0] r_dly_cnt;
   logic [FW-1:0] r_frame_cnt;
   logic          r_power_en;
   logic          r_timing_en;
   logic          r_reset_req;
   logic          r_backlight_en;
   logic          r_ready;

   logic [2:0]    w_next_state;
   logic [DW-1:0] w_dly_load;
   logic [FW:0]   w_frame_inc;
   logic          w_frame_count_en;
   logic          w_power_en;
   logic          w_timing_en;
   logic          w_reset_req;
   logic          w_backlight_en;
   logic          w_ready;

   assign w_frame_inc      = {1'b0, r_frame_cnt} + (FW + 1)'(1);
   assign w_frame_count_en = i_frame_tick && ((r_state == S_SYNC_WAIT) || (r_state == S_STOP_WAIT));

   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= S_OFF;
         r_power_en     <= 1'b0;
         r_timing_en    <= 1'b0;
         r_reset_req    <= 1'b0;
         r_backlight_en <= 1'b0;
         r_ready        <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_power_en     <= w_power_en;
         r_timing_en    <= w_timing_en;
         r_reset_req    <= w_reset_req;
         r_backlight_en <= w_backlight_en;
         r_ready        <= w_ready;
      end
   end

   // Aborts are checked before the normal exit so they win on a coincident cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_OFF:       if ((r_dly_cnt == '0) && i_power_request) w_next_state = S_PWR_UP;
         S_PWR_UP:    if (!i_power_request) w_next_state = S_PWR_DOWN;
                      else if (r_dly_cnt == '0) w_next_state = S_SYNC_WAIT;
         S_SYNC_WAIT: if (!i_power_request) w_next_state = S_PWR_DOWN;
                      else if (i_frame_tick && (w_frame_inc >= SYNC_N)) w_next_state = S_ON;
         S_ON:        if (!i_power_request) w_next_state = S_BL_OFF;
         S_BL_OFF:    if (r_dly_cnt == '0) w_next_state = S_STOP_WAIT;
         S_STOP_WAIT: if (i_frame_tick && (w_frame_inc >= STOP_N)) w_next_state = S_PWR_DOWN;
         S_PWR_DOWN:  if (r_dly_cnt == '0) w_next_state = S_OFF;
         default:     w_next_state = S_PWR_DOWN;
      endcase
   end

   always_comb begin
      w_power_en     = (w_next_state != S_OFF) && (w_next_state != 3'd7);
      w_timing_en    = (w_next_state == S_SYNC_WAIT) || (w_next_state == S_ON) ||
                       (w_next_state == S_BL_OFF) || (w_next_state == S_STOP_WAIT);
      w_backlight_en = (w_next_state == S_ON);
      w_ready        = (w_next_state == S_ON);
      w_reset_req    = (r_state == S_PWR_UP) && (w_next_state == S_SYNC_WAIT);
      w_dly_load     = '0;
      case (w_next_state)
         S_OFF:      w_dly_load = LD_OFF_MIN;
         S_PWR_UP:   w_dly_load = LD_PWR_UP;
         S_BL_OFF:   w_dly_load = LD_BL_OFF;
         S_PWR_DOWN: w_dly_load = LD_PWR_DOWN;
         default:    w_dly_load = '0;
      endcase
   end

   // Reset leaves the delay counter at 0 so the first power-up is not held off.
   always_ff @(posedge i_master_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_dly_cnt   <= '0;
         r_frame_cnt <= '0;
      end else if (w_next_state != r_state) begin
         r_dly_cnt   <= w_dly_load;
         r_frame_cnt <= '0;
      end else begin
         if (r_dly_cnt != '0) r_dly_cnt <= r_dly_cnt - DW'(1);
         if (w_frame_count_en) r_frame_cnt <= r_frame_cnt + FW'(1);
      end
   end

   assign o_panel_power_en       = r_power_en;
   assign o_timing_enabled       = r_timing_en;
   assign o_timing_reset_request = r_reset_req;
   assign o_backlight_en         = r_backlight_en;
   assign o_ready                = r_ready;
   assign o_state                = r_state;

endmodule
